xor_checksum_accumulator: RTL
=============================

XOR_CHECKSUM_ACCUMULATOR -- requirements
Module: xor_checksum_accumulator

Interface
REQ-001 Parameter: LEN_W, default 8, width of the block-length and word-count fields.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: start  input  1  begin a new block; sampled only in IDLE.
REQ-005 Port: len  input  LEN_W  number of 32-bit words in the block; sampled with start.
REQ-006 Port: in_valid  input  1  upstream word valid.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: in_data  input  32  word to fold into the checksum.
REQ-009 Port: out_valid  output  1  checksum result valid.
REQ-010 Port: out_ready  input  1  downstream consumes the result.
REQ-011 Port: checksum  output  32  XOR of all accepted words of the block.
REQ-012 Port: parity  output  1  XOR-reduction of checksum.
REQ-013 Port: count  output  LEN_W  words accepted in the current block.
REQ-014 Port: busy  output  1  high in ACCUM and DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 The fold datapath SHALL compute acc_next = acc XOR in_data through the team's thirty_two_bit_xor component, which feeds the 32-bit accumulator register.
REQ-017 IDLE: in_ready=0, out_valid=0, busy=0; with start=1 and len!=0, the next cycle SHALL have acc=0, count=0, stored length=len, state=ACCUM.
REQ-018 IDLE with start=1 and len=0: the next state SHALL be DONE with checksum=0 and count=0 (empty block).
REQ-019 ACCUM: in_ready SHALL be 1 combinationally from the state only; a transfer occurs when in_valid&&in_ready.
REQ-020 On each transfer: acc <= acc^in_data and count <= count+1; no transfer leaves acc and count unchanged (in_valid gaps allowed).
REQ-021 The transfer that makes count equal the stored length SHALL move the FSM to DONE on the same edge; in_ready SHALL be 0 from the next cycle.
REQ-022 Latency: out_valid SHALL rise exactly 1 cycle after the last transfer edge; checksum, parity and count SHALL be registered and stable for the whole time out_valid=1.
REQ-023 DONE: out_valid=1 and in_ready=0; out_valid&&out_ready SHALL return the FSM to IDLE on that edge, and out_valid SHALL be 0 the next cycle.
REQ-024 DONE without out_ready SHALL hold all outputs indefinitely (backpressure).
REQ-025 start SHALL be ignored in ACCUM and DONE, including the cycle in which DONE is exited; a new block starts only from IDLE.
REQ-026 len=2^LEN_W-1 SHALL be supported; count SHALL never wrap, because the block exits ACCUM at count==len.
REQ-027 In IDLE, checksum and count SHALL retain the last block's values until the next start clears them.
REQ-028 Words presented while in_ready=0 SHALL NOT be accepted or alter any state.

Reset
REQ-029 On a rising clk edge with rst_n=0: state=IDLE, acc=0, count=0, stored length=0, out_valid=0, in_ready=0, busy=0, parity=0.
REQ-030 Reset SHALL take priority over every other input, including mid-block in ACCUM or DONE; a partial block is discarded and the first post-reset block starts only with a new start.
REQ-031 Outputs SHALL be defined (no X) from the first edge on which rst_n=0 is sampled.

Verification
REQ-032 start, len=3; words 0x0000_00FF, 0xFF00_0000, 0x0F0F_0F0F back-to-back -> checksum=0xF00F_0FF0, parity=0, count=3, out_valid 1 cycle after third transfer.
REQ-033 len=4; words 0xA5A5_A5A5, 0xA5A5_A5A5, 0x0000_0001, 0x8000_0000 with in_valid gaps of 0-3 cycles -> checksum=0x8000_0001, parity=0, count=4.
REQ-034 len=1, word 0x1234_5678, out_ready held 0 for 10 cycles -> out_valid and checksum=0x1234_5678 (parity=1) stable for all 10 cycles, then 1 cycle with out_ready=1 -> IDLE the next cycle.
REQ-035 start with len=0 -> out_valid=1 the next cycle, checksum=0, count=0, no word accepted even with in_valid=1.
REQ-036 len=5, rst_n=0 after 2 transfers -> all outputs at reset values; new start, len=1, word 0xDEAD_BEEF -> checksum=0xDEAD_BEEF with no residue from the aborted block.
REQ-037 start pulsed during ACCUM and DONE of a len=2 block -> ignored: count reaches 2 and the result is presented exactly once.

Source files
------------

// File: rtl/xor_checksum_accumulator.sv
// ---------------------------------------------------------------------------
// xor_checksum_accumulator
//
// Folds a block of 32-bit words into a running XOR checksum. A block is
// opened from IDLE by start with its word count on len, words are taken
// through a valid/ready handshake while in ACCUM, and the result is held in
// DONE until the downstream consumer accepts it.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : open a new block (honoured only in IDLE)
//   len        : number of words in the block, sampled with start
//   in_valid   : upstream word valid
//   in_ready   : block accepts in_data this cycle (high only in ACCUM)
//   in_data    : word to fold into the checksum
//   out_valid  : checksum result valid (high only in DONE)
//   out_ready  : downstream consumes the result
//   checksum   : XOR of all accepted words of the block
//   parity     : XOR-reduction of checksum
//   count      : words accepted in the current block
//   busy       : high in ACCUM and DONE
// ---------------------------------------------------------------------------

// 32-bit bitwise XOR used as the fold datapath.
module thirty_two_bit_xor (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module xor_checksum_accumulator #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      checksum,
  output logic             parity,
  output logic [LEN_W-1:0] count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_acc;
  logic [31:0]      w_acc_next;
  logic [31:0]      w_acc_fold;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_next;
  logic [LEN_W-1:0] w_count_inc;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_next;

  thirty_two_bit_xor u_fold (
    .i_a (r_acc),
    .i_b (in_data),
    .o_y (w_acc_fold)
  );

  // count < r_len holds throughout ACCUM, so the increment never wraps.
  assign w_count_inc = r_count + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_len   <= w_len_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_len_next   = r_len;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_next   = '0;
          w_count_next = '0;
          w_len_next   = len;
          // An empty block goes straight to DONE with a zero result.
          w_state_next = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          w_acc_next   = w_acc_fold;
          w_count_next = w_count_inc;
          if (w_count_inc == r_len) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the state register alone, so they
  // never depend combinationally on in_valid/out_ready.
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign checksum  = r_acc;
  assign parity    = ^r_acc;
  assign count     = r_count;

endmodule
